seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised multi-cycle ALU that generalises the existing 16-bit ALU to WIDTH-bit operands, with proper sequential execution. Single-cycle ops finish in one cycle. MUL, DIV, MOD and the rotates run iteratively, one bit per cycle. It sits between the control FSM and the register file, and uses a bgn/rdy handshake with registered results and flags.

Parameters:
WIDTH, 16, operand/result width in bits (≥4)
CNTW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
bgn  input  1  start request, sampled only in IDLE
opcode  input  5  operation, shared opcode encoding
a  input  WIDTH  operand A
b  input  WIDTH  operand B / shift or rotate count
acc1  output  WIDTH  result low / quotient
acc2  output  WIDTH  result high / remainder
zero  output  1  registered zero flag
negative  output  1  registered sign flag
carry  output  1  registered carry/borrow flag
overflow  output  1  registered overflow flag
rdy  output  1  one-cycle completion pulse
busy  output  1  high from accept until completion
halted  output  1  sticky, set by HLT

Behaviour:
- Reset (async, any state, including mid-operation): all outputs 0; state IDLE; iteration counter 0; in-flight op discarded.
- States: IDLE, EXEC, DONE.
  - IDLE: bgn=1 and halted=0 at edge k → latch a, b, opcode; busy=1.
  - Single-cycle ops go straight to DONE. Iterative ops go to EXEC.
  - EXEC decrements the counter each cycle and moves to DONE when it reaches 0.
  - DONE writes acc1/acc2/flags, pulses rdy=1 for exactly one cycle, clears busy, returns to IDLE.
- Latency, measured from accept edge k:
  - Single-cycle ops: rdy high after edge k+1.
  - MUL/DIV/MOD: rdy high after edge k+WIDTH+1.
  - RSR/RSL: rdy high after edge k+1+(b mod WIDTH).
  - Back-to-back: next bgn is accepted on the edge following the rdy cycle.
- bgn while busy: ignored, no queueing. Inputs other than at accept: don't-care.
- Single-cycle op results (acc2=0 unless stated):
  - ADD: a+b. SUB: a−b. INC: a+1. DEC: a−1.
  - AND, OR, XOR, NOT (~a).
  - LSL/LSR: logical shift by b; b≥WIDTH yields 0.
- MUL: unsigned shift-add; {acc2,acc1} = full 2·WIDTH product.
- DIV/MOD: unsigned restoring division; both write acc1=quotient, acc2=remainder.
- Divide by zero: completes in 1 cycle; acc1=all-ones, acc2=a, overflow=1.
- RSR/RSL: rotate a by (b mod WIDTH) positions, one position per EXEC cycle; a count of 0 completes as a single-cycle op.
- CMP and TST update flags only; acc1/acc2 retain their previous values.
  - CMP flags come from a−b.
  - TST flags come from a&b.
- NOP and unknown opcodes: complete in 1 cycle; accumulators and flags unchanged.
- HLT: completes in 1 cycle and sets halted. While halted, every bgn is ignored. Only rst clears halted.
- Flags are updated only in DONE, from the op's full result R:
  - zero = (R==0); for MUL/DIV/MOD, R is the pair {acc2,acc1}.
  - negative = MSB of acc2 for MUL, otherwise MSB of acc1/R.
  - carry = carry-out for ADD/INC; borrow for SUB/CMP/DEC (a<b, or a==0 for DEC); 0 otherwise.
  - overflow = signed two's-complement overflow for ADD/SUB/CMP/INC/DEC; (acc2≠0) for MUL; divide-by-zero for DIV/MOD; 0 otherwise.

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams: HLT=0, ADD=1, SUB=2, LSR=3, LSL=4, RSR=5, RSL=6, MUL=7, DIV=8, MOD=9, AND=10, OR=11, XOR=12, NOT=13, CMP=14, TST=15, INC=16, DEC=17, NOP=31;
  - the state encoding (IDLE, EXEC, DONE);
  - a flag-index enum.
- Sub-module alu_iter_dp holds the iterative datapath: product/partial-remainder register pair, rotate register, and counter. The top-level FSM drives its load and step signals.

Test Plan:
1. ADD a=0x7FFF, b=0x0001 → acc1=0x8000, acc2=0; overflow=1, negative=1, carry=0, zero=0; rdy one cycle after accept, busy low again with rdy.
2. MUL a=0x1234, b=0x0100 → acc2=0x0012, acc1=0x3400, overflow=1; rdy exactly 17 edges after accept. A bgn pulsed at cycle 5 is ignored.
3. DIV a=100, b=7 → acc1=14, acc2=2, overflow=0. Then DIV a=0x00AB, b=0 → acc1=0xFFFF, acc2=0x00AB, overflow=1, rdy after 1 cycle.
4. RSL a=0x8001, b=4 → acc1=0x0018 after 5 edges. RSL with b=20 gives the same result and latency. RSR a=0x0001, b=1 → 0x8000.
5. Precondition acc1=0x5555. CMP a=3, b=5 → carry=1, negative=1, zero=0, acc1 still 0x5555.
6. Assert rst at cycle 8 of a MUL → all outputs 0 immediately; fresh ADD 2+2 afterwards gives 4. HLT → halted=1; a following bgn with ADD gives no rdy and busy stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, FSM states,
// iterative-op kinds and flag bit positions.
package alu_pkg;

    localparam logic [4:0] OP_HLT = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_LSR = 5'd3;
    localparam logic [4:0] OP_LSL = 5'd4;
    localparam logic [4:0] OP_RSR = 5'd5;
    localparam logic [4:0] OP_RSL = 5'd6;
    localparam logic [4:0] OP_MUL = 5'd7;
    localparam logic [4:0] OP_DIV = 5'd8;
    localparam logic [4:0] OP_MOD = 5'd9;
    localparam logic [4:0] OP_AND = 5'd10;
    localparam logic [4:0] OP_OR  = 5'd11;
    localparam logic [4:0] OP_XOR = 5'd12;
    localparam logic [4:0] OP_NOT = 5'd13;
    localparam logic [4:0] OP_CMP = 5'd14;
    localparam logic [4:0] OP_TST = 5'd15;
    localparam logic [4:0] OP_INC = 5'd16;
    localparam logic [4:0] OP_DEC = 5'd17;
    localparam logic [4:0] OP_NOP = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        IT_MUL,
        IT_DIV,
        IT_RSL,
        IT_RSR
    } iter_kind_e;

    typedef enum logic [1:0] {
        FLAG_Z = 2'd0,
        FLAG_N = 2'd1,
        FLAG_C = 2'd2,
        FLAG_V = 2'd3
    } flag_idx_e;

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_iter_dp.sv
// Iterative datapath: shift-add multiplier, restoring divider and
// one-position-per-cycle rotator, sharing a single down-counter.
module alu_iter_dp
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  iter_kind_e       kind,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNTW-1:0]  cnt_init,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rot,
    output logic             cnt_last
);

    iter_kind_e       kind_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] rot_q;
    logic [CNTW-1:0]  cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] div_diff;

    // hi/lo double as product {hi,lo} for MUL and as remainder/quotient for DIV
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_fits  = (div_shift >= {1'b0, opb_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q <= IT_MUL;
            opb_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            rot_q  <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            kind_q <= kind;
            opb_q  <= b;
            hi_q   <= '0;
            lo_q   <= a;
            rot_q  <= a;
            cnt_q  <= cnt_init;
        end else if (step) begin
            cnt_q <= cnt_q - CNTW'(1);
            case (kind_q)
                IT_MUL: begin
                    hi_q <= mul_sum[WIDTH:1];
                    lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                IT_DIV: begin
                    hi_q <= div_fits ? div_diff : div_shift[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], div_fits};
                end
                IT_RSL: rot_q <= {rot_q[WIDTH-2:0], rot_q[WIDTH-1]};
                IT_RSR: rot_q <= {rot_q[0], rot_q[WIDTH-1:1]};
                default: ;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign rot      = rot_q;
    assign cnt_last = (cnt_q == CNTW'(1));

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle WIDTH-bit ALU with bgn/rdy handshake; results and flags are
// registered and written only when the operation completes.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bgn,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc1,
    output logic [WIDTH-1:0] acc2,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             rdy,
    output logic             busy,
    output logic             halted
);

    localparam int               CNTW  = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    state_e           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] acc1_q, acc2_q;
    logic [3:0]       flags_q;
    logic             rdy_q, halted_q;

    logic             accept, needs_exec, dp_load, dp_step, cnt_last;
    iter_kind_e       dp_kind;
    logic [CNTW-1:0]  cnt_init;
    logic [WIDTH-1:0] rot_amt, dp_hi, dp_lo, dp_rot;

    assign accept  = (state == IDLE) && bgn && !halted_q;
    assign rot_amt = b % W_VAL;

    alu_iter_dp #(.WIDTH(WIDTH), .CNTW(CNTW)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (dp_load),
        .step     (dp_step),
        .kind     (dp_kind),
        .a        (a),
        .b        (b),
        .cnt_init (cnt_init),
        .hi       (dp_hi),
        .lo       (dp_lo),
        .rot      (dp_rot),
        .cnt_last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Divide by zero and zero-count rotates never enter EXEC
    always_comb begin
        state_nx   = state;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        dp_kind    = IT_MUL;
        cnt_init   = '0;
        needs_exec = 1'b0;
        case (opcode)
            OP_MUL: begin
                dp_kind    = IT_MUL;
                cnt_init   = CNTW'(WIDTH);
                needs_exec = 1'b1;
            end
            OP_DIV, OP_MOD: begin
                dp_kind    = IT_DIV;
                cnt_init   = CNTW'(WIDTH);
                needs_exec = (b != '0);
            end
            OP_RSL: begin
                dp_kind    = IT_RSL;
                cnt_init   = CNTW'(rot_amt);
                needs_exec = (rot_amt != '0);
            end
            OP_RSR: begin
                dp_kind    = IT_RSR;
                cnt_init   = CNTW'(rot_amt);
                needs_exec = (rot_amt != '0);
            end
            default: ;
        endcase
        case (state)
            IDLE: if (accept) begin
                dp_load  = 1'b1;
                state_nx = needs_exec ? EXEC : DONE;
            end
            EXEC: begin
                dp_step = 1'b1;
                if (cnt_last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    logic [WIDTH-1:0] opnd2, add_res, sub_res, and_res, simple_res, div_q, div_r;
    logic [WIDTH:0]   add_full;
    logic             add_v, sub_v, borrow, div0;
    logic [WIDTH-1:0] nxt_acc1, nxt_acc2;
    logic [3:0]       nxt_flags;

    assign opnd2    = (op_q == OP_INC || op_q == OP_DEC) ? WIDTH'(1) : b_q;
    assign add_full = {1'b0, a_q} + {1'b0, opnd2};
    assign add_res  = add_full[WIDTH-1:0];
    assign sub_res  = a_q - opnd2;
    assign and_res  = a_q & b_q;
    assign borrow   = (a_q < opnd2);
    assign add_v    = (a_q[WIDTH-1] == opnd2[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
    assign sub_v    = (a_q[WIDTH-1] != opnd2[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
    assign div0     = (b_q == '0);
    assign div_q    = div0 ? '1  : dp_lo;
    assign div_r    = div0 ? a_q : dp_hi;

    always_comb begin
        simple_res = '0;
        case (op_q)
            OP_AND:         simple_res = and_res;
            OP_OR:          simple_res = a_q | b_q;
            OP_XOR:         simple_res = a_q ^ b_q;
            OP_NOT:         simple_res = ~a_q;
            OP_LSL:         simple_res = (b_q >= W_VAL) ? '0 : (a_q << b_q);
            OP_LSR:         simple_res = (b_q >= W_VAL) ? '0 : (a_q >> b_q);
            OP_RSL, OP_RSR: simple_res = dp_rot;
            default: ;
        endcase
    end

    // CMP/TST, NOP, HLT and unknown opcodes leave the accumulators untouched
    always_comb begin
        nxt_acc1  = acc1_q;
        nxt_acc2  = acc2_q;
        nxt_flags = flags_q;
        case (op_q)
            OP_ADD, OP_INC: begin
                nxt_acc1  = add_res;
                nxt_acc2  = '0;
                nxt_flags = pack_flags(add_res == '0, add_res[WIDTH-1], add_full[WIDTH], add_v);
            end
            OP_SUB, OP_DEC: begin
                nxt_acc1  = sub_res;
                nxt_acc2  = '0;
                nxt_flags = pack_flags(sub_res == '0, sub_res[WIDTH-1], borrow, sub_v);
            end
            OP_CMP: nxt_flags = pack_flags(sub_res == '0, sub_res[WIDTH-1], borrow, sub_v);
            OP_TST: nxt_flags = pack_flags(and_res == '0, and_res[WIDTH-1], 1'b0, 1'b0);
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR, OP_RSL, OP_RSR: begin
                nxt_acc1  = simple_res;
                nxt_acc2  = '0;
                nxt_flags = pack_flags(simple_res == '0, simple_res[WIDTH-1], 1'b0, 1'b0);
            end
            OP_MUL: begin
                nxt_acc1  = dp_lo;
                nxt_acc2  = dp_hi;
                nxt_flags = pack_flags({dp_hi, dp_lo} == '0, dp_hi[WIDTH-1], 1'b0, dp_hi != '0);
            end
            OP_DIV, OP_MOD: begin
                nxt_acc1  = div_q;
                nxt_acc2  = div_r;
                nxt_flags = pack_flags({div_r, div_q} == '0, div_q[WIDTH-1], 1'b0, div0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_NOP;
            acc1_q   <= '0;
            acc2_q   <= '0;
            flags_q  <= '0;
            rdy_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (accept) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= opcode;
            end
            if (state == DONE) begin
                acc1_q  <= nxt_acc1;
                acc2_q  <= nxt_acc2;
                flags_q <= nxt_flags;
                rdy_q   <= 1'b1;
                if (op_q == OP_HLT) halted_q <= 1'b1;
            end
        end
    end

    assign acc1     = acc1_q;
    assign acc2     = acc2_q;
    assign zero     = flags_q[FLAG_Z];
    assign negative = flags_q[FLAG_N];
    assign carry    = flags_q[FLAG_C];
    assign overflow = flags_q[FLAG_V];
    assign rdy      = rdy_q;
    assign busy     = (state != IDLE);
    assign halted   = halted_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16) with hand-computed
// expected results, latencies and flags.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst, bgn;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] a, b, acc1, acc2;
    logic             zero, negative, carry, overflow, rdy, busy, halted;

    int total = 0;
    int bad   = 0;
    int edges;
    int rdyHits, busyHits;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .bgn(bgn), .opcode(opcode), .a(a), .b(b),
        .acc1(acc1), .acc2(acc2), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .rdy(rdy), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                            input logic ez, input logic en, input logic ec, input logic ev);
        checkOutput({tag, ".acc1"}, acc1, e1);
        checkOutput({tag, ".acc2"}, acc2, e2);
        checkOutput({tag, ".zero"}, zero, ez);
        checkOutput({tag, ".neg"}, negative, en);
        checkOutput({tag, ".carry"}, carry, ec);
        checkOutput({tag, ".ovf"}, overflow, ev);
        checkOutput({tag, ".busy"}, busy, 1'b0);
    endtask

    // Leaves the bench 1 time unit after the accept edge with bgn dropped
    task automatic applyStimulus(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        opcode = op;
        a      = av;
        b      = bv;
        bgn    = 1'b1;
        @(posedge clk);
        #1;
        bgn = 1'b0;
    endtask

    // Counts edges after accept until rdy; returns maxEdges+1 on timeout
    task automatic waitRdy(input int maxEdges, input int glitchAt, output int n);
        n = 0;
        while (n <= maxEdges) begin
            @(posedge clk);
            #1;
            n++;
            if (n == glitchAt) begin
                bgn    = 1'b1;
                opcode = OP_ADD;
                a      = 16'h0001;
                b      = 16'h0001;
            end else begin
                bgn = 1'b0;
            end
            if (rdy) break;
        end
        bgn = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [4:0] op, input logic [15:0] av,
                         input logic [15:0] bv, input int lat, input logic [15:0] e1,
                         input logic [15:0] e2, input logic ez, input logic en,
                         input logic ec, input logic ev);
        int n;
        applyStimulus(op, av, bv);
        checkOutput({tag, ".busyAcc"}, busy, 1'b1);
        waitRdy(lat + 4, 0, n);
        checkOutput({tag, ".lat"}, n, lat);
        checkAll(tag, e1, e2, ez, en, ec, ev);
    endtask

    initial begin
        rst = 1'b1; bgn = 1'b0; opcode = OP_NOP; a = '0; b = '0;
        #1;
        checkAll("reset", 16'h0, 16'h0, 0, 0, 0, 0);
        checkOutput("reset.rdy", rdy, 1'b0);
        checkOutput("reset.halted", halted, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        runOp("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0, 0, 1, 0, 1);

        applyStimulus(OP_MUL, 16'h1234, 16'h0100);
        waitRdy(25, 4, edges);
        checkOutput("mul.lat", edges, 17);
        checkAll("mul", 16'h3400, 16'h0012, 0, 0, 0, 1);
        rdyHits = 0; busyHits = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rdy) rdyHits++;
            if (busy) busyHits++;
        end
        checkOutput("mul.noQueueRdy", rdyHits, 0);
        checkOutput("mul.noQueueBusy", busyHits, 0);

        runOp("div", OP_DIV, 16'd100, 16'd7, 17, 16'd14, 16'd2, 0, 0, 0, 0);
        runOp("mod", OP_MOD, 16'd1000, 16'd33, 17, 16'd30, 16'd10, 0, 0, 0, 0);
        runOp("div0", OP_DIV, 16'h00AB, 16'h0, 1, 16'hFFFF, 16'h00AB, 0, 1, 0, 1);

        runOp("rsl4", OP_RSL, 16'h8001, 16'd4, 5, 16'h0018, 16'h0, 0, 0, 0, 0);
        runOp("rsl20", OP_RSL, 16'h8001, 16'd20, 5, 16'h0018, 16'h0, 0, 0, 0, 0);
        runOp("rsr1", OP_RSR, 16'h0001, 16'd1, 2, 16'h8000, 16'h0, 0, 1, 0, 0);
        runOp("rsl16", OP_RSL, 16'h1234, 16'd16, 1, 16'h1234, 16'h0, 0, 0, 0, 0);

        runOp("mulmax", OP_MUL, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 0, 1, 0, 1);
        runOp("mulsmall", OP_MUL, 16'd3, 16'd5, 17, 16'd15, 16'h0, 0, 0, 0, 0);

        runOp("inc_wrap", OP_INC, 16'hFFFF, 16'h1234, 1, 16'h0000, 16'h0, 1, 0, 1, 0);
        runOp("dec_ovf", OP_DEC, 16'h8000, 16'h0000, 1, 16'h7FFF, 16'h0, 0, 0, 0, 1);
        runOp("dec_zero", OP_DEC, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'h0, 0, 1, 1, 0);
        runOp("lsl16", OP_LSL, 16'h00FF, 16'd16, 1, 16'h0000, 16'h0, 1, 0, 0, 0);
        runOp("lsr15", OP_LSR, 16'h8000, 16'd15, 1, 16'h0001, 16'h0, 0, 0, 0, 0);
        runOp("xor", OP_XOR, 16'hF0F0, 16'hFF00, 1, 16'h0FF0, 16'h0, 0, 0, 0, 0);
        runOp("not", OP_NOT, 16'h00FF, 16'h0, 1, 16'hFF00, 16'h0, 0, 1, 0, 0);

        runOp("pre", OP_OR, 16'h5555, 16'h0000, 1, 16'h5555, 16'h0, 0, 0, 0, 0);
        runOp("cmp", OP_CMP, 16'd3, 16'd5, 1, 16'h5555, 16'h0, 0, 1, 1, 0);
        runOp("tst", OP_TST, 16'h00F0, 16'h000F, 1, 16'h5555, 16'h0, 1, 0, 0, 0);
        runOp("nop", OP_NOP, 16'h1111, 16'h2222, 1, 16'h5555, 16'h0, 1, 0, 0, 0);
        runOp("sub", OP_SUB, 16'd5, 16'd3, 1, 16'd2, 16'h0, 0, 0, 0, 0);

        applyStimulus(OP_MUL, 16'h00FF, 16'h00FF);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkAll("midRst", 16'h0, 16'h0, 0, 0, 0, 0);
        checkOutput("midRst.rdy", rdy, 1'b0);
        checkOutput("midRst.halted", halted, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        runOp("addAfterRst", OP_ADD, 16'd2, 16'd2, 1, 16'd4, 16'h0, 0, 0, 0, 0);

        runOp("hlt", OP_HLT, 16'h0, 16'h0, 1, 16'd4, 16'h0, 0, 0, 0, 0);
        checkOutput("hlt.halted", halted, 1'b1);
        applyStimulus(OP_ADD, 16'd1, 16'd1);
        checkOutput("halted.busyAcc", busy, 1'b0);
        rdyHits = 0; busyHits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy) rdyHits++;
            if (busy) busyHits++;
        end
        checkOutput("halted.rdy", rdyHits, 0);
        checkOutput("halted.busy", busyHits, 0);
        checkOutput("halted.acc1", acc1, 16'd4);

        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstHalt.halted", halted, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        runOp("addAfterHalt", OP_ADD, 16'd3, 16'd4, 1, 16'd7, 16'h0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
